// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: sequences the ADC front-end, waits for a sample whose
// distance from mid-scale reaches a threshold, then frames a fixed number of
// PACKET_LEN-beat packets (TLAST on the last beat) through a small FIFO.
// Optional build macro: ADC_CAPTURE_SIGNED_EN -- output samples as
// sign-extended two's complement (code - 2048) instead of offset binary.
module adc_capture_ctrl #(
  parameter int PACKET_LEN = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic        CTRL_START,
  input  logic        CTRL_STOP,
  input  logic [11:0] CTRL_THRESHOLD,
  input  logic [7:0]  CTRL_NUM_PACKETS,
  output logic        STATUS_BUSY,
  output logic        STATUS_OVERFLOW,
  output logic        ADC_EN,
  input  logic        S_AXIS_TVALID,
  input  logic [15:0] S_AXIS_TDATA,
  output logic        S_AXIS_TREADY,
  output logic        M_AXIS_TVALID,
  output logic [15:0] M_AXIS_TDATA,
  output logic [1:0]  M_AXIS_TSTRB,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(PACKET_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]    pkt_cnt_q, pkt_cnt_d;
  logic [7:0]    num_pkts_q, num_pkts_d;
  logic          stop_pend_q, stop_pend_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [12:0]   mem [FIFO_DEPTH];

  logic [11:0]   code;
  logic [11:0]   mag;
  logic          trig;
  logic          beat_last;
  logic [PW-1:0] occupancy;
  logic          pop;
  logic          out_free;
  logic          mem_empty;
  logic          has_space;
  logic          wr_en;
  logic          mem_we;
  logic [12:0]   wr_word;
  logic [12:0]   mem_rd;
  logic          unused_tdata_hi;

  // Output word format; the bench-visible difference between the two builds.
  function automatic logic [15:0] fmt_data(input logic [11:0] c);
`ifdef ADC_CAPTURE_SIGNED_EN
    // code - 2048 is code with the MSB inverted; sign-extend that bit.
    fmt_data = {{4{~c[11]}}, ~c[11], c[10:0]};
`else
    fmt_data = {4'b0000, c};
`endif
  endfunction

  assign code            = S_AXIS_TDATA[11:0];
  assign unused_tdata_hi = ^S_AXIS_TDATA[15:12];
  assign mag             = (code < 12'd2048) ? (12'd2048 - code) : (code - 12'd2048);
  assign trig            = (mag >= CTRL_THRESHOLD);
  assign beat_last       = (beat_cnt_q == LAST_BEAT);

  // Occupancy counts the output register too, so FIFO_DEPTH beats total.
  assign occupancy = (wr_ptr_q - rd_ptr_q) + PW'(out_valid_q);
  assign pop       = out_valid_q & M_AXIS_TREADY;
  assign out_free  = ~out_valid_q | pop;
  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign has_space = (occupancy != PW'(FIFO_DEPTH)) | pop;
  assign wr_word   = {beat_last, code};
  assign mem_rd    = mem[rd_ptr_q[AW-1:0]];

  assign STATUS_BUSY     = (state_q != ST_IDLE);
  assign ADC_EN          = (state_q == ST_ARMED) | (state_q == ST_CAPTURE);
  assign STATUS_OVERFLOW = ovf_q;
  assign S_AXIS_TREADY   = 1'b1;
  assign M_AXIS_TVALID   = out_valid_q;
  assign M_AXIS_TDATA    = out_data_q;
  assign M_AXIS_TLAST    = out_last_q;
  assign M_AXIS_TSTRB    = 2'b11;

  // Capture FSM: next state, counters and the FIFO write request.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    num_pkts_d  = num_pkts_q;
    stop_pend_d = stop_pend_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (CTRL_START && !CTRL_STOP) begin
          state_d     = ST_ARMED;
          ovf_d       = 1'b0;
          beat_cnt_d  = '0;
          pkt_cnt_d   = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (CTRL_STOP) begin
          state_d = ST_IDLE;
        end else if (S_AXIS_TVALID && trig) begin
          state_d    = ST_CAPTURE;
          num_pkts_d = CTRL_NUM_PACKETS;
          if (has_space) begin
            wr_en      = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (CTRL_STOP && beat_cnt_q == '0) begin
          // Already on a packet boundary: nothing partial to finish.
          state_d = ST_DRAIN;
        end else begin
          if (CTRL_STOP) stop_pend_d = 1'b1;
          if (S_AXIS_TVALID) begin
            if (has_space) begin
              wr_en = 1'b1;
              if (beat_last) begin
                beat_cnt_d = '0;
                pkt_cnt_d  = pkt_cnt_q + 8'd1;
                if (stop_pend_q || CTRL_STOP ||
                    (num_pkts_q != 8'd0 && (pkt_cnt_q + 8'd1) == num_pkts_q))
                  state_d = ST_DRAIN;
              end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
              end
            end else begin
              // Dropped beats leave the beat counter alone.
              ovf_d = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (mem_empty && (!out_valid_q || pop)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers and the registered first-word-fall-through output stage.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    if (out_free) begin
      if (!mem_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = fmt_data(mem_rd[11:0]);
        out_last_d  = mem_rd[12];
        rd_ptr_d    = rd_ptr_q + PW'(1);
      end else if (wr_en) begin
        out_valid_d = 1'b1;
        out_data_d  = fmt_data(wr_word[11:0]);
        out_last_d  = wr_word[12];
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // Write goes to memory unless it was bypassed straight to the output.
    if (wr_en && !(out_free && mem_empty)) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge AXIS_ACLK) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  // State and datapath registers.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      num_pkts_q  <= '0;
      stop_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      num_pkts_q  <= num_pkts_d;
      stop_pend_q <= stop_pend_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
